vertex_fetch: RTL and testbench
===============================

# vertex_fetch

Reads fixed-size primitive records (four data words each) out of the vertex RAM through its four-word read window and presents them one at a time to the rasterizer front end with a valid/ready handshake. It sits between the RAM that the host loads through the write port and the line/triangle drawing engines, and it owns the RAM read address. A run is started with a base address and a record count. `done` pulses when the last record has been accepted downstream.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: RAM address width. Record addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: RAM word width.
- `COUNT_WIDTH`, default 6: width of the record count.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: one-cycle request. Sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH: word address of the first record. Sampled with `start`.
- `prim_count`  in  COUNT_WIDTH: number of records to fetch. Sampled with `start`.
- `ram_read_addr`  out  ADDR_WIDTH: drives the RAM read address.
- `ram_read_data1`..`ram_read_data4`  in  DATA_WIDTH each: RAM words at addr, addr+1, addr+2, addr+3. Combinational from `ram_read_addr`.
- `prim_valid`  out  1: a record is held on `prim_word0..3`.
- `prim_ready`  in  1: downstream accepts the record.
- `prim_word0`..`prim_word3`  out  DATA_WIDTH each: captured record.
- `prim_index`  out  COUNT_WIDTH: ordinal of the presented record within the run, starting at 0.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a run.

## Operation
- The FSM has four states: IDLE, ADDR, HOLD, FIN.
- IDLE:
  - On `start`, latch `base_addr` into the address register, load `remaining` from `prim_count`, and clear `prim_index`.
  - If `prim_count` is 0, go to FIN. Otherwise go to ADDR.
- ADDR:
  - `ram_read_addr` has been stable for this whole cycle.
  - At the edge, capture `ram_read_data1..4` into `prim_word0..3` and go to HOLD.
- HOLD:
  - `prim_valid` is 1, and `prim_word*` and `prim_index` stay stable until the transfer.
  - A transfer happens when `prim_valid` and `prim_ready` are both high at a rising edge.
  - On transfer, decrement `remaining`. If the new value is 0, go to FIN. Otherwise add 4 to the address register (modulo 2^ADDR_WIDTH), increment `prim_index`, and go to ADDR.
- FIN: `done` is 1 for exactly this cycle, then go to IDLE.
- `ram_read_addr` always equals the address register.
- `start` while `busy` is ignored: no queuing and no effect.
- A record that starts near the top of the address space wraps. With ADDR_WIDTH=8, base 0xFE reads words 0xFE, 0xFF, 0x00, 0x01. This follows directly from the RAM's address arithmetic.
- Reset, asynchronous and possibly mid-run, forces:
  - state IDLE;
  - address register, `remaining`, `prim_index` = 0;
  - `prim_word0..3` = 0;
  - `prim_valid`, `busy`, `done` = 0.
- No record is presented after reset until a new `start`.

## Timing
- Edge 0 samples `start`. Cycle 1 is ADDR. Edge 2 captures the data. `prim_valid` is 1 from cycle 2.
- Start-to-first-valid latency is 2 cycles.
- Best-case throughput, with `prim_ready` held high, is one record per 2 cycles.
- `done` is asserted in the cycle after the final transfer.
- With `prim_count`=0, `done` is asserted in cycle 1.
- `busy` rises in the cycle after the `start` edge and falls when FIN exits.
- A new `start` is accepted in the first IDLE cycle after FIN.
- Outputs are registered except `busy`, which is decoded from state.

## Configuration
- `VERTEX_FETCH_SKIP_NULL_EN`: records whose type field `ram_read_data1[31:30]` equals 2'b00 are null records.
- Defined:
  - At the ADDR capture edge, a null record is not presented. `remaining` decrements.
  - If `remaining` reaches 0, go to FIN. Otherwise advance the address by 4 and stay in ADDR.
  - `prim_index` still counts every record, so indices skip.
  - Each skipped record costs 1 cycle.
- Undefined: every record is presented regardless of its type field.

## Structure
- Package `gp_pkg` holds:
  - the FSM state enum (IDLE/ADDR/HOLD/FIN);
  - `REC_STRIDE`=4;
  - the type-field constants `PRIM_NULL`=2'b00, `PRIM_LINE`=2'b01, `PRIM_TRI`=2'b10.
- No sub-module. The address and count logic is small enough to stay in one module.

## Test plan
- Base 0x10, count 3, ready always 1, RAM[0x10..0x1B] = 0x100..0x10B:
  - valid at cycles 2, 4, 6;
  - words 0x100–0x103, then 0x104–0x107, then 0x108–0x10B;
  - `prim_index` 0, 1, 2;
  - `done` at cycle 7.
- Backpressure: count 2, `prim_ready` low for 5 cycles on the first record. Valid and words stay stable throughout, and `ram_read_addr` stays at 0x10. The second record follows 2 cycles after the transfer.
- Count 0 → `done` at cycle 1, `prim_valid` never asserted, `busy` high for exactly 1 cycle.
- Wrap: base 0xFE, count 1 → words = RAM[0xFE], RAM[0xFF], RAM[0x00], RAM[0x01].
- `rst_n` dropped while in HOLD of record 1 of 3 → all outputs 0 immediately. A `start` pulsed while busy in a separate run produces no extra records.
- With `VERTEX_FETCH_SKIP_NULL_EN`, count 3 and the middle record's type field = 00 → two records presented, with `prim_index` 0 and 2.

Source files
------------

// File: rtl/gp_pkg.sv
// Shared types and constants for the vertex fetch unit: FSM states, record
// stride in RAM words, and the primitive type-field encodings.
package gp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int REC_STRIDE = 4;

  localparam logic [1:0] PRIM_NULL = 2'b00;
  localparam logic [1:0] PRIM_LINE = 2'b01;
  localparam logic [1:0] PRIM_TRI  = 2'b10;

endpackage

// File: rtl/vertex_fetch.sv
// Walks a run of four-word primitive records in vertex RAM and presents each one downstream.
// Optional VERTEX_FETCH_SKIP_NULL_EN drops records whose type field is PRIM_NULL.
module vertex_fetch
  import gp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] prim_count,
  output logic [ADDR_WIDTH-1:0]  ram_read_addr,
  input  logic [DATA_WIDTH-1:0]  ram_read_data1,
  input  logic [DATA_WIDTH-1:0]  ram_read_data2,
  input  logic [DATA_WIDTH-1:0]  ram_read_data3,
  input  logic [DATA_WIDTH-1:0]  ram_read_data4,
  output logic                   prim_valid,
  input  logic                   prim_ready,
  output logic [DATA_WIDTH-1:0]  prim_word0,
  output logic [DATA_WIDTH-1:0]  prim_word1,
  output logic [DATA_WIDTH-1:0]  prim_word2,
  output logic [DATA_WIDTH-1:0]  prim_word3,
  output logic [COUNT_WIDTH-1:0] prim_index,
  output logic                   busy,
  output logic                   done,
  output state_t                 dbg_state
);

  // Handshake: a record transfers on a rising edge where prim_valid and
  // prim_ready are both high; prim_valid never drops and the record never
  // changes until that transfer has happened.

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [COUNT_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0]  r_word0, r_word1, r_word2, r_word3;
  logic                   r_valid;
  logic                   r_done;

  logic w_last;
  logic w_is_null;

  assign w_last = (r_remaining == COUNT_WIDTH'(1));

`ifdef VERTEX_FETCH_SKIP_NULL_EN
  assign w_is_null = (ram_read_data1[31:30] == PRIM_NULL);
`else
  assign w_is_null = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_index     <= '0;
      r_word0     <= '0;
      r_word1     <= '0;
      r_word2     <= '0;
      r_word3     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= prim_count;
            r_index     <= '0;
            if (prim_count == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (w_is_null) begin
            // A dropped record still consumes its slot and its index.
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            if (w_last) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + ADDR_WIDTH'(REC_STRIDE);
              r_index <= r_index + COUNT_WIDTH'(1);
            end
          end else begin
            r_word0 <= ram_read_data1;
            r_word1 <= ram_read_data2;
            r_word2 <= ram_read_data3;
            r_word3 <= ram_read_data4;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (prim_ready) begin
            r_valid     <= 1'b0;
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            if (w_last) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_addr  <= r_addr + ADDR_WIDTH'(REC_STRIDE);
              r_index <= r_index + COUNT_WIDTH'(1);
              r_state <= ADDR;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_read_addr = r_addr;
  assign prim_valid    = r_valid;
  assign prim_word0    = r_word0;
  assign prim_word1    = r_word1;
  assign prim_word2    = r_word2;
  assign prim_word3    = r_word3;
  assign prim_index    = r_index;
  assign done          = r_done;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_vertex_fetch.sv
// Bench for vertex_fetch: directed table of runs, hand-written reset/skip sequences,
// and randomized runs checked against a record-list model of the RAM walk.
module tb_vertex_fetch;
  import gp_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 6;

`ifdef VERTEX_FETCH_SKIP_NULL_EN
  localparam logic [31:0] TAG = 32'h4000_0000;
`else
  localparam logic [31:0] TAG = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] prim_count;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data1, ram_read_data2, ram_read_data3, ram_read_data4;
  logic          prim_valid;
  logic          prim_ready;
  logic [DW-1:0] prim_word0, prim_word1, prim_word2, prim_word3;
  logic [CW-1:0] prim_index;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  logic [DW-1:0] ram [0:255];
  logic [AW-1:0] a1, a2, a3;

  assign a1 = ram_read_addr + 8'd1;
  assign a2 = ram_read_addr + 8'd2;
  assign a3 = ram_read_addr + 8'd3;
  assign ram_read_data1 = ram[ram_read_addr];
  assign ram_read_data2 = ram[a1];
  assign ram_read_data3 = ram[a2];
  assign ram_read_data4 = ram[a3];

  always #5 clk = ~clk;

  vertex_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .prim_count(prim_count), .ram_read_addr(ram_read_addr),
    .ram_read_data1(ram_read_data1), .ram_read_data2(ram_read_data2),
    .ram_read_data3(ram_read_data3), .ram_read_data4(ram_read_data4),
    .prim_valid(prim_valid), .prim_ready(prim_ready),
    .prim_word0(prim_word0), .prim_word1(prim_word1),
    .prim_word2(prim_word2), .prim_word3(prim_word3),
    .prim_index(prim_index), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Expected record: address, index, words, and ADDR cycles spent before it
  // (1 plus any null records skipped right before it).
  typedef struct {
    logic [CW-1:0] idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] w0, w1, w2, w3;
    int            gap;
  } rec_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    int            low;
    int            pct;
    bit            poke;
    int            exp_done;
  } vec_t;

  rec_t          exp_q[$];
  logic [CW-1:0] seen_idx[$];
  int            tail_skips;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_model(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
    int gap;
    exp_q.delete();
    gap = 1;
    for (int i = 0; i < int'(cnt); i++) begin
      rec_t          r;
      logic [AW-1:0] a;
      bit            skip;
      a      = base + 8'(4 * i);
      r.idx  = 6'(i);
      r.addr = a;
      r.w0   = ram[a];
      r.w1   = ram[8'(a + 8'd1)];
      r.w2   = ram[8'(a + 8'd2)];
      r.w3   = ram[8'(a + 8'd3)];
      skip   = 1'b0;
`ifdef VERTEX_FETCH_SKIP_NULL_EN
      skip = (r.w0[31:30] == 2'b00);
`endif
      if (skip) gap++;
      else begin
        r.gap = gap;
        exp_q.push_back(r);
        gap = 1;
      end
    end
    tail_skips = gap - 1;
  endfunction

  task automatic run(input logic [AW-1:0] base, input logic [CW-1:0] cnt, input int low,
                     input int pct, input bit poke, input int exp_done);
    int  valid_at, done_at, obs_done, stall_left;
    bit  exp_valid;
    rec_t r;
    build_model(base, cnt);
    seen_idx.delete();
    done_at  = -1;
    valid_at = 0;
    obs_done = -1;
    stall_left = low;
    @(negedge clk);
    start = 1'b1; base_addr = base; prim_count = cnt; prim_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'($urandom); prim_count = 6'($urandom);
    if (exp_q.size() > 0) valid_at = 1 + exp_q[0].gap;
    else done_at = 1 + tail_skips;
    for (int c = 1; c <= 400; c++) begin
      prim_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < pct);
      start = poke && (c == 3);
      @(negedge clk);
      exp_valid = (exp_q.size() > 0) && (c >= valid_at);
      chk("valid", prim_valid, exp_valid);
      chk("busy", busy, (done_at < 0) || (c <= done_at));
      chk("done", done, c == done_at);
      if (done) obs_done = c;
      if (exp_valid) begin
        r = exp_q[0];
        chk("word0", prim_word0, r.w0);
        chk("word1", prim_word1, r.w1);
        chk("word2", prim_word2, r.w2);
        chk("word3", prim_word3, r.w3);
        chk("index", prim_index, r.idx);
        chk("rd_addr", ram_read_addr, r.addr);
        if (prim_ready) begin
          seen_idx.push_back(prim_index);
          void'(exp_q.pop_front());
          if (exp_q.size() > 0) valid_at = c + 1 + exp_q[0].gap;
          else done_at = c + 1 + tail_skips;
        end else if (stall_left > 0) stall_left--;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("run_finished", done_at >= 0 && obs_done >= 0, 1);
    if (exp_done >= 0) chk("done_cycle", obs_done, exp_done);
  endtask

  vec_t vecs[5];

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; prim_count = '0; prim_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = $urandom | TAG;
    for (int i = 0; i < 12; i++) ram[8'h10 + i] = TAG | (32'h100 + 32'(i));
    ram[8'hFE] = TAG | 32'hA0; ram[8'hFF] = TAG | 32'hA1;
    ram[8'h00] = TAG | 32'hA2; ram[8'h01] = TAG | 32'hA3;

    #12;
    chk("rst_valid", prim_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_read_addr, 0);
    chk("rst_word0", prim_word0, 0);
    chk("rst_index", prim_index, 0);
    @(negedge clk); rst_n = 1'b1;

    vecs[0] = '{base: 8'h10, cnt: 6'd3, low: 0, pct: 100, poke: 1'b0, exp_done: 7};
    vecs[1] = '{base: 8'h10, cnt: 6'd2, low: 5, pct: 100, poke: 1'b0, exp_done: 10};
    vecs[2] = '{base: 8'h10, cnt: 6'd0, low: 0, pct: 100, poke: 1'b0, exp_done: 1};
    vecs[3] = '{base: 8'hFE, cnt: 6'd1, low: 0, pct: 100, poke: 1'b0, exp_done: 3};
    vecs[4] = '{base: 8'h10, cnt: 6'd3, low: 0, pct: 100, poke: 1'b1, exp_done: 7};
    for (int v = 0; v < 5; v++)
      run(vecs[v].base, vecs[v].cnt, vecs[v].low, vecs[v].pct, vecs[v].poke, vecs[v].exp_done);
    chk("poke_records", seen_idx.size(), 3);

    // Reset while record 1 of 3 is held.
    begin
      bit hit;
      hit = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = 8'h10; prim_count = 6'd3; prim_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        if (prim_valid && prim_index == 6'd1) begin
          prim_ready = 1'b0;
          hit = 1'b1;
        end
      end
      chk("reach_rec1", hit, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", prim_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_addr", ram_read_addr, 0);
      chk("mid_rst_index", prim_index, 0);
      chk("mid_rst_words", prim_word0 | prim_word1 | prim_word2 | prim_word3, 0);
      @(negedge clk); rst_n = 1'b1; prim_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk("post_rst_idle", {prim_valid, busy, done}, 0);
      end
    end

`ifdef VERTEX_FETCH_SKIP_NULL_EN
    for (int i = 0; i < 12; i++) ram[8'h40 + i] = TAG | 32'(i);
    ram[8'h44] = 32'h0000_1234;
    run(8'h40, 6'd3, 0, 100, 1'b0, 6);
    chk("skip_count", seen_idx.size(), 2);
    if (seen_idx.size() == 2) begin
      chk("skip_idx0", seen_idx[0], 0);
      chk("skip_idx1", seen_idx[1], 2);
    end
`endif

    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    for (int n = 0; n < 25; n++)
      run(8'($urandom), 6'($urandom_range(0, 7)), $urandom_range(0, 3),
          $urandom_range(30, 100), 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
